// File: rtl/axis_measure_sequencer_pkg.sv
// Shared definitions for the measurement sequencer: the measurer's register
// map and command words, sequencer error codes and the FSM state type.
package axis_measure_sequencer_pkg;

  localparam int STORE_DATA_WIDTH = 32;

  // Register map of axis_measure_top's s_axi_control port (byte offsets).
  localparam logic [31:0] CONTROL_OFFSET    = 32'h0000_0000;
  localparam logic [31:0] CYCLES_OFFSET     = 32'h0000_0010;
  localparam logic [31:0] LAST_FRAME_OFFSET = 32'h0000_0018;

  // Command words written to CONTROL_OFFSET.
  localparam logic [31:0] SIG_CLEAR = 32'h0000_0001;
  localparam logic [31:0] SIG_START = 32'h0000_0002;

  // Abort reasons reported on err_code.
  localparam logic [1:0] SEQ_ERR_NONE    = 2'b00;
  localparam logic [1:0] SEQ_ERR_RESP    = 2'b01;
  localparam logic [1:0] SEQ_ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CLR,
    ST_WR_STA,
    ST_RUN,
    ST_RD_LO,
    ST_RD_HI,
    ST_RD_LF
  } seq_state_t;

  // States that own exactly one AXI-Lite transaction.
  function automatic logic is_xfer_state(input seq_state_t s);
    return (s != ST_IDLE) && (s != ST_RUN);
  endfunction

endpackage

// File: rtl/axis_measure_sequencer_xfer.sv
// Single-transaction AXI-Lite master engine: runs one write or one read per
// request, checks the response and aborts a channel phase that stalls too long.
// All AXI outputs come straight from registers.
module axil_master_xfer
  import axis_measure_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        xfer_done,
  output logic        xfer_err,
  output logic [1:0]  xfer_err_code,
  output logic [31:0] rd_data,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic              aw_valid_reg, w_valid_reg, b_ready_reg, ar_valid_reg, r_ready_reg;
  logic [31:0]       awaddr_reg, wdata_reg, araddr_reg;
  logic [TMR_W-1:0]  timer_reg;
  logic              active, accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
  logic              timeout_hit, resp_err, wr_addr_data_done;

  assign active = aw_valid_reg | w_valid_reg | b_ready_reg | ar_valid_reg | r_ready_reg;
  assign accept = req_valid & ~active;
  assign aw_hs  = aw_valid_reg & m_axi_awready;
  assign w_hs   = w_valid_reg & m_axi_wready;
  assign b_hs   = b_ready_reg & m_axi_bvalid;
  assign ar_hs  = ar_valid_reg & m_axi_arready;
  assign r_hs   = r_ready_reg & m_axi_rvalid;
  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  // Address and data may complete in either order or together; B opens once both have.
  assign wr_addr_data_done = (aw_valid_reg | w_valid_reg) &
                             (~aw_valid_reg | aw_hs) & (~w_valid_reg | w_hs);

  assign timeout_hit   = active & ~any_hs & (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));
  assign resp_err      = (b_hs & (m_axi_bresp != 2'b00)) | (r_hs & (m_axi_rresp != 2'b00));
  assign xfer_done     = (b_hs & (m_axi_bresp == 2'b00)) | (r_hs & (m_axi_rresp == 2'b00));
  assign xfer_err      = resp_err | timeout_hit;
  assign xfer_err_code = timeout_hit ? SEQ_ERR_TIMEOUT : (resp_err ? SEQ_ERR_RESP : SEQ_ERR_NONE);
  assign rd_data       = m_axi_rdata;

  assign m_axi_awaddr  = awaddr_reg;
  assign m_axi_awvalid = aw_valid_reg;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = 4'b1111;
  assign m_axi_wvalid  = w_valid_reg;
  assign m_axi_bready  = b_ready_reg;
  assign m_axi_araddr  = araddr_reg;
  assign m_axi_arvalid = ar_valid_reg;
  assign m_axi_rready  = r_ready_reg;

  // Channel handshake state: raise valids on a request, drop each after its own handshake.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      aw_valid_reg <= 1'b0;
      w_valid_reg  <= 1'b0;
      b_ready_reg  <= 1'b0;
      ar_valid_reg <= 1'b0;
      r_ready_reg  <= 1'b0;
      awaddr_reg   <= '0;
      wdata_reg    <= '0;
      araddr_reg   <= '0;
    end else if (timeout_hit) begin
      aw_valid_reg <= 1'b0;
      w_valid_reg  <= 1'b0;
      b_ready_reg  <= 1'b0;
      ar_valid_reg <= 1'b0;
      r_ready_reg  <= 1'b0;
    end else if (accept) begin
      if (req_write) begin
        aw_valid_reg <= 1'b1;
        w_valid_reg  <= 1'b1;
        awaddr_reg   <= req_addr;
        wdata_reg    <= req_wdata;
      end else begin
        ar_valid_reg <= 1'b1;
        araddr_reg   <= req_addr;
      end
    end else begin
      if (aw_hs) aw_valid_reg <= 1'b0;
      if (w_hs) w_valid_reg <= 1'b0;
      if (wr_addr_data_done) b_ready_reg <= 1'b1;
      if (b_hs) b_ready_reg <= 1'b0;
      if (ar_hs) begin
        ar_valid_reg <= 1'b0;
        r_ready_reg  <= 1'b1;
      end
      if (r_hs) r_ready_reg <= 1'b0;
    end
  end

  // Stall timer: counts cycles without progress, restarting on every handshake.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      timer_reg <= '0;
    end else if (accept || any_hs || !active || timeout_hit) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

endmodule

// File: rtl/axis_measure_sequencer.sv
// Measurement sequencer: on cmd_start writes CLEAR then START to the measurer,
// waits the requested number of cycles, reads back the cycle count and last
// frame, and reports them with a done pulse (or err pulse on abort).
module axis_measure_sequencer
  import axis_measure_sequencer_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        cmd_start,
  input  logic [31:0] cmd_run_cycles,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [63:0] cycles,
  output logic [31:0] last_frame,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  seq_state_t  state_reg, state_next;
  logic [31:0] run_cnt_reg;
  logic        issued_reg, busy_reg, done_reg, err_reg;
  logic [1:0]  err_code_reg;
  logic [31:0] cyc_lo_reg, cyc_hi_reg, last_frame_reg;
  logic [63:0] cycles_reg;
  logic        accept;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        xfer_done, xfer_err;
  logic [1:0]  xfer_err_code;
  logic [STORE_DATA_WIDTH-1:0] rd_data;

  assign accept     = (state_reg == ST_IDLE) & cmd_start;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign err_code   = err_code_reg;
  assign cycles     = cycles_reg;
  assign last_frame = last_frame_reg;

  axil_master_xfer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_xfer (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .xfer_done(xfer_done), .xfer_err(xfer_err), .xfer_err_code(xfer_err_code), .rd_data(rd_data),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // Next state and the transaction each state asks the engine for.
  always_comb begin
    state_next = state_reg;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    case (state_reg)
      ST_IDLE: if (cmd_start) state_next = ST_WR_CLR;
      ST_WR_CLR: begin
        req_write = 1'b1;
        req_addr  = BASE_ADDR + CONTROL_OFFSET;
        req_wdata = SIG_CLEAR;
        if (xfer_err) state_next = ST_IDLE;
        else if (xfer_done) state_next = ST_WR_STA;
      end
      ST_WR_STA: begin
        req_write = 1'b1;
        req_addr  = BASE_ADDR + CONTROL_OFFSET;
        req_wdata = SIG_START;
        if (xfer_err) state_next = ST_IDLE;
        else if (xfer_done) state_next = (run_cnt_reg == 32'd0) ? ST_RD_LO : ST_RUN;
      end
      ST_RUN: if (run_cnt_reg <= 32'd1) state_next = ST_RD_LO;
      ST_RD_LO: begin
        req_addr = BASE_ADDR + CYCLES_OFFSET;
        if (xfer_err) state_next = ST_IDLE;
        else if (xfer_done) state_next = ST_RD_HI;
      end
      ST_RD_HI: begin
        req_addr = BASE_ADDR + CYCLES_OFFSET + 32'd4;
        if (xfer_err) state_next = ST_IDLE;
        else if (xfer_done) state_next = ST_RD_LF;
      end
      ST_RD_LF: begin
        req_addr = BASE_ADDR + LAST_FRAME_OFFSET;
        if (xfer_err || xfer_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // One request per state, issued in its first cycle while the engine is idle.
    req_valid = is_xfer_state(state_reg) & ~issued_reg;
  end

  // State register, run counter and status pulses.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_reg    <= ST_IDLE;
      issued_reg   <= 1'b0;
      run_cnt_reg  <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= SEQ_ERR_NONE;
    end else begin
      state_reg  <= state_next;
      issued_reg <= (state_next == state_reg) & (issued_reg | req_valid);
      if (accept) run_cnt_reg <= cmd_run_cycles;
      else if (state_reg == ST_RUN) run_cnt_reg <= run_cnt_reg - 32'd1;
      busy_reg <= (state_next != ST_IDLE);
      done_reg <= (state_reg == ST_RD_LF) & xfer_done;
      err_reg  <= xfer_err;
      if (accept) err_code_reg <= SEQ_ERR_NONE;
      else if (xfer_err) err_code_reg <= xfer_err_code;
    end
  end

  // Readback capture; published results only change when the last read succeeds.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cyc_lo_reg     <= '0;
      cyc_hi_reg     <= '0;
      cycles_reg     <= '0;
      last_frame_reg <= '0;
    end else if (xfer_done) begin
      if (state_reg == ST_RD_LO) cyc_lo_reg <= rd_data;
      if (state_reg == ST_RD_HI) cyc_hi_reg <= rd_data;
      if (state_reg == ST_RD_LF) begin
        cycles_reg     <= {cyc_hi_reg, cyc_lo_reg};
        last_frame_reg <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_axis_measure_sequencer.sv
// Directed bench for axis_measure_sequencer with a configurable AXI-Lite stub
// slave; expected results are queued when a command is issued and compared
// when done/err appears.
module tb_axis_measure_sequencer;
  import axis_measure_sequencer_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          TMO  = 16;

  logic        ap_clk = 1'b0, ap_rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic [31:0] cmd_run_cycles = '0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [63:0] cycles;
  logic [31:0] last_frame;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axis_measure_sequencer #(.TIMEOUT_CYCLES(TMO), .BASE_ADDR(BASE)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .cmd_start(cmd_start), .cmd_run_cycles(cmd_run_cycles),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .cycles(cycles),
    .last_frame(last_frame),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // Stub slave configuration, set by the stimulus.
  int          aw_delay = 0;
  logic        bresp_err_start = 1'b0;
  logic        ar_never = 1'b0;
  logic [31:0] rd_lo = '0, rd_hi = '0, rd_lf = '0;

  logic        w_got, aw_got;
  int          aw_cnt;
  logic [31:0] w_data_q, aw_addr_q;
  logic [31:0] obs_wr_addr_q[$], obs_wr_data_q[$], obs_rd_addr_q[$];

  // AXI-Lite stub slave.
  always @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      arready <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
      w_got <= 1'b0; aw_got <= 1'b0; aw_cnt <= 0; w_data_q <= '0; aw_addr_q <= '0;
    end else begin
      awready <= 1'b0;
      wready  <= 1'b0;
      arready <= 1'b0;
      if (wvalid && !wready && !w_got) wready <= 1'b1;
      if (wvalid && wready) begin
        w_got <= 1'b1; w_data_q <= wdata; aw_cnt <= aw_delay;
      end else if (w_got && aw_cnt > 0) aw_cnt <= aw_cnt - 1;
      if (awvalid && !awready && !aw_got && (aw_delay == 0 || (w_got && aw_cnt == 0)))
        awready <= 1'b1;
      if (awvalid && awready) begin
        aw_got <= 1'b1; aw_addr_q <= awaddr;
      end
      if (aw_got && w_got && !bvalid) begin
        bvalid <= 1'b1;
        bresp  <= (bresp_err_start && w_data_q == SIG_START) ? 2'b10 : 2'b00;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        obs_wr_addr_q.push_back(aw_addr_q);
        obs_wr_data_q.push_back(w_data_q);
      end
      if (arvalid && !arready && !rvalid && !ar_never) arready <= 1'b1;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rresp  <= 2'b00;
        if (araddr == BASE + CYCLES_OFFSET) rdata <= rd_lo;
        else if (araddr == BASE + CYCLES_OFFSET + 32'd4) rdata <= rd_hi;
        else if (araddr == BASE + LAST_FRAME_OFFSET) rdata <= rd_lf;
        else rdata <= 32'hDEAD_BEEF;
        obs_rd_addr_q.push_back(araddr);
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // Protocol monitor sampled on the falling edge.
  int   t_b = 0;
  int   ar_rise_t_q[$], ar_gap_q[$];
  int   bready_bad = 0, drop_bad = 0, w_first_cnt = 0, done_cnt = 0;
  logic prev_ar = 1'b0, prev_aw_hs = 1'b0, prev_w_hs = 1'b0;
  always @(negedge ap_clk) begin
    if (bvalid && bready) t_b <= cyc;
    if (arvalid && !prev_ar) begin
      ar_rise_t_q.push_back(cyc);
      ar_gap_q.push_back(cyc - t_b);
    end
    if (bready && (awvalid || wvalid)) bready_bad <= bready_bad + 1;
    if ((prev_aw_hs && awvalid) || (prev_w_hs && wvalid)) drop_bad <= drop_bad + 1;
    if (awvalid && !wvalid) w_first_cnt <= w_first_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    prev_ar    <= arvalid;
    prev_aw_hs <= awvalid && awready;
    prev_w_hs  <= wvalid && wready;
  end

  typedef struct {
    logic        is_err;
    logic [1:0]  code;
    logic [63:0] cyc_val;
    logic [31:0] lf_val;
  } exp_t;
  exp_t exp_q[$];

  int          checks = 0, failures = 0;
  int          t_evt = 0;
  logic [63:0] model_cycles = '0;
  logic [31:0] model_lf = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {busy, done, err, err_code}, '0);
    check({tag, "_cycles"}, cycles, '0);
    check({tag, "_last_frame"}, last_frame, '0);
    check({tag, "_axi_vr"}, {awvalid, wvalid, bready, arvalid, rready}, '0);
    check({tag, "_axi_addr"}, {awaddr, araddr}, '0);
    check({tag, "_axi_wdata"}, wdata, '0);
  endtask

  task automatic push_done(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] lf);
    exp_t e;
    model_cycles = {hi, lo};
    model_lf     = lf;
    e.is_err = 1'b0; e.code = SEQ_ERR_NONE; e.cyc_val = model_cycles; e.lf_val = model_lf;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.cyc_val = model_cycles; e.lf_val = model_lf;
    exp_q.push_back(e);
  endtask

  task automatic run_cmd(input logic [31:0] n);
    @(negedge ap_clk);
    cmd_start = 1'b1; cmd_run_cycles = n;
    @(negedge ap_clk);
    cmd_start = 1'b0;
  endtask

  // Waits for done or err (bounded), then compares against the scoreboard head.
  task automatic wait_and_compare(input string tag, input int budget);
    bit   seen = 1'b0;
    logic got_err = 1'b0;
    exp_t e;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge ap_clk);
      if (done || err) begin
        seen = 1'b1; got_err = err; t_evt = cyc;
      end
    end
    check({tag, "_event_seen"}, seen, 1'b1);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_has_entry"}, 0, 1);
    end else if (seen) begin
      e = exp_q.pop_front();
      check({tag, "_is_err"}, got_err, e.is_err);
      check({tag, "_err_code"}, err_code, e.code);
      check({tag, "_cycles"}, cycles, e.cyc_val);
      check({tag, "_last_frame"}, last_frame, e.lf_val);
      check({tag, "_busy_low"}, busy, 1'b0);
    end
  endtask

  initial begin
    int wr_i, rd_i, ar_i, d0, bb0, db0, wf0;
    bit found;
    $display("tb_axis_measure_sequencer: start");

    // Reset state
    repeat (3) @(negedge ap_clk);
    check_outputs_zero("reset_held");
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check_outputs_zero("reset_released");

    // 1: normal run, same-cycle AW/W acceptance, 20-cycle wait
    rd_lo = 32'd25; rd_hi = 32'd3; rd_lf = 32'd30; aw_delay = 0;
    wr_i = obs_wr_addr_q.size(); rd_i = obs_rd_addr_q.size(); ar_i = ar_gap_q.size();
    push_done(rd_lo, rd_hi, rd_lf);
    run_cmd(32'd20);
    wait_and_compare("t1", 300);
    $display("txn t1: run=20 done cycles=%0h last_frame=%0d", cycles, last_frame);
    check("t1_write_count", obs_wr_addr_q.size() - wr_i, 2);
    check("t1_wr0_addr", obs_wr_addr_q[wr_i], BASE + CONTROL_OFFSET);
    check("t1_wr0_data", obs_wr_data_q[wr_i], SIG_CLEAR);
    check("t1_wr1_data", obs_wr_data_q[wr_i+1], SIG_START);
    check("t1_read_count", obs_rd_addr_q.size() - rd_i, 3);
    check("t1_rd0_addr", obs_rd_addr_q[rd_i], BASE + CYCLES_OFFSET);
    check("t1_rd1_addr", obs_rd_addr_q[rd_i+1], BASE + CYCLES_OFFSET + 32'd4);
    check("t1_rd2_addr", obs_rd_addr_q[rd_i+2], BASE + LAST_FRAME_OFFSET);
    check("t1_start_to_ar_gap", ar_gap_q[ar_i], 20 + 2);
    check("t1_wstrb", wstrb, 4'b1111);

    // 2: AW accepted two cycles after W
    rd_lo = 32'd7; rd_hi = 32'd1; rd_lf = 32'd99; aw_delay = 2;
    bb0 = bready_bad; db0 = drop_bad; wf0 = w_first_cnt;
    push_done(rd_lo, rd_hi, rd_lf);
    run_cmd(32'd3);
    wait_and_compare("t2", 300);
    $display("txn t2: late awready done cycles=%0h last_frame=%0d", cycles, last_frame);
    check("t2_w_dropped_before_aw", w_first_cnt > wf0, 1'b1);
    check("t2_bready_only_after_both", bready_bad - bb0, 0);
    check("t2_valid_drop_after_hs", drop_bad - db0, 0);
    aw_delay = 0;

    // 3: SLVERR on the START write
    bresp_err_start = 1'b1;
    ar_i = ar_rise_t_q.size();
    push_err(SEQ_ERR_RESP);
    run_cmd(32'd5);
    wait_and_compare("t3", 300);
    $display("txn t3: bresp error err_code=%0b", err_code);
    @(negedge ap_clk);
    check("t3_err_single_pulse", err, 1'b0);
    repeat (10) @(negedge ap_clk);
    check("t3_no_ar_issued", ar_rise_t_q.size() - ar_i, 0);
    bresp_err_start = 1'b0;

    // 4: arready never comes
    ar_never = 1'b1;
    ar_i = ar_rise_t_q.size();
    push_err(SEQ_ERR_TIMEOUT);
    run_cmd(32'd0);
    wait_and_compare("t4", 300);
    $display("txn t4: ar timeout err_code=%0b", err_code);
    if (ar_rise_t_q.size() > ar_i)
      check("t4_err_delay_from_arvalid", t_evt - ar_rise_t_q[ar_i], TMO);
    else
      check("t4_arvalid_seen", 0, 1);
    check("t4_arvalid_low_at_err", arvalid, 1'b0);
    @(negedge ap_clk);
    check("t4_valids_low_after", {arvalid, rready, awvalid, wvalid, bready}, '0);
    repeat (5) @(negedge ap_clk);
    check("t4_err_code_held", err_code, SEQ_ERR_TIMEOUT);
    ar_never = 1'b0;

    // 5: zero run count, second cmd_start while busy
    rd_lo = 32'h111; rd_hi = 32'h0; rd_lf = 32'h55;
    d0 = done_cnt; rd_i = obs_rd_addr_q.size(); ar_i = ar_gap_q.size();
    push_done(rd_lo, rd_hi, rd_lf);
    run_cmd(32'd0);
    repeat (2) @(negedge ap_clk);
    check("t5_busy_during_run", busy, 1'b1);
    cmd_start = 1'b1; cmd_run_cycles = 32'd7;
    @(negedge ap_clk);
    cmd_start = 1'b0;
    wait_and_compare("t5", 300);
    $display("txn t5: run=0 done cycles=%0h last_frame=%0h", cycles, last_frame);
    check("t5_ar_follows_bresp", ar_gap_q[ar_i], 2);
    repeat (40) @(negedge ap_clk);
    check("t5_single_done", done_cnt - d0, 1);
    check("t5_single_readback", obs_rd_addr_q.size() - rd_i, 3);

    // 6: reset in RD_HI, then a clean run
    rd_lo = 32'd5; rd_hi = 32'd6; rd_lf = 32'd7;
    push_done(rd_lo, rd_hi, rd_lf);
    run_cmd(32'd2);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge ap_clk);
      if (arvalid && araddr == BASE + CYCLES_OFFSET + 32'd4) found = 1'b1;
    end
    check("t6_reached_rd_hi", found, 1'b1);
    #2 ap_rst = 1'b1;
    #1 check_outputs_zero("t6_async_reset");
    $display("txn t6: reset asserted during RD_HI");
    void'(exp_q.pop_back());  // the interrupted command never reports
    model_cycles = '0; model_lf = '0;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    rd_lo = 32'hAAAA; rd_hi = 32'hBBBB; rd_lf = 32'hCCCC;
    wr_i = obs_wr_addr_q.size(); rd_i = obs_rd_addr_q.size();
    push_done(rd_lo, rd_hi, rd_lf);
    run_cmd(32'd4);
    wait_and_compare("t6_clean", 300);
    $display("txn t6: clean run done cycles=%0h last_frame=%0h", cycles, last_frame);
    check("t6_write_count", obs_wr_addr_q.size() - wr_i, 2);
    check("t6_read_count", obs_rd_addr_q.size() - rd_i, 3);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
